tspi_swap_ctrl: RTL and testbench

Block-swap controller between the core-side request interface and the TSPI flash fetch engine. It keeps a tag table mapping 21-bit flash block addresses to on-chip SRAM slots and returns each requester's slot index on a hit. On a miss it stalls the core via `block_o`, picks one missing requester round-robin, picks a victim slot, and drives a single fetch through the TSPI engine before releasing the stall. It sits in the user domain between the croc domain's request ports and the TSPI master.

---
 rtl/tspi_swap_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_tspi_swap_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tspi_swap_ctrl.sv
// Block-swap controller: tag lookup from flash block address to SRAM slot, with one fetch at a time through the TSPI engine.
// Optional hit/miss statistics outputs are enabled by defining TSPI_SWAP_STATS_EN.
module tspi_swap_ctrl #(
  parameter int NumReq    = 2,
  parameter int NumSlots  = 4,
  parameter int AddrWidth = 21,
  parameter int IdxWidth  = $clog2(NumSlots)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]                  valid_i,
  output logic [NumReq-1:0][IdxWidth-1:0]    sram_addr_idx_o,
  output logic                               block_o,
  output logic                               fetch_req_o,
  input  logic                               fetch_gnt_i,
  output logic [AddrWidth-1:0]               fetch_addr_o,
  output logic [IdxWidth-1:0]                fetch_slot_o,
  input  logic                               fetch_done_i
`ifdef TSPI_SWAP_STATS_EN
  ,
  output logic [15:0]                        hit_count_o,
  output logic [15:0]                        miss_count_o
`endif
);

  localparam int ReqW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   tag_q [NumSlots];
  logic [AddrWidth-1:0]   tag_d [NumSlots];
  logic [NumSlots-1:0]    vld_q, vld_d;
  logic [IdxWidth-1:0]    repl_ptr_q, repl_ptr_d;
  logic [ReqW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ReqW-1:0]        sel_req_q, sel_req_d;
  logic                   fetch_req_q, fetch_req_d;
  logic [AddrWidth-1:0]   fetch_addr_q, fetch_addr_d;
  logic [IdxWidth-1:0]    fetch_slot_q, fetch_slot_d;

  logic [NumReq-1:0]      hit;
  logic [NumReq-1:0]      miss_vec;
  logic [NumSlots-1:0]    pinned;
  logic [ReqW-1:0]        sel_req;
  logic [IdxWidth-1:0]    victim;
  logic                   sel_found;
  logic                   victim_found;

  // A slot any valid requester currently hits is pinned and must not be evicted.
  always_comb begin
    hit             = '0;
    pinned          = '0;
    sram_addr_idx_o = '0;
    for (int r = 0; r < NumReq; r++) begin
      for (int s = 0; s < NumSlots; s++) begin
        if (valid_i[r] && vld_q[s] && (tag_q[s] == req_addr_i[r])) begin
          hit[r]             = 1'b1;
          pinned[s]          = 1'b1;
          sram_addr_idx_o[r] = IdxWidth'(s);
        end
      end
    end
  end

  assign miss_vec = valid_i & ~hit;
  assign block_o  = (|miss_vec) | (state_q != IDLE);

  always_comb begin
    sel_req   = rr_ptr_q;
    sel_found = 1'b0;
    for (int i = 1; i <= NumReq; i++) begin
      if (!sel_found && miss_vec[(int'(rr_ptr_q) + i) % NumReq]) begin
        sel_req   = ReqW'((int'(rr_ptr_q) + i) % NumReq);
        sel_found = 1'b1;
      end
    end
  end

  // NumSlots > NumReq guarantees at least one unpinned slot exists.
  always_comb begin
    victim       = repl_ptr_q;
    victim_found = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!victim_found && !pinned[(int'(repl_ptr_q) + i) % NumSlots]) begin
        victim       = IdxWidth'((int'(repl_ptr_q) + i) % NumSlots);
        victim_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    vld_d        = vld_q;
    repl_ptr_d   = repl_ptr_q;
    rr_ptr_d     = rr_ptr_q;
    sel_req_d    = sel_req_q;
    fetch_req_d  = fetch_req_q;
    fetch_addr_d = fetch_addr_q;
    fetch_slot_d = fetch_slot_q;
    case (state_q)
      IDLE: begin
        if (|miss_vec) begin
          state_d       = ISSUE;
          fetch_req_d   = 1'b1;
          fetch_addr_d  = req_addr_i[sel_req];
          fetch_slot_d  = victim;
          sel_req_d     = sel_req;
          vld_d[victim] = 1'b0;
        end
      end
      ISSUE: begin
        if (fetch_gnt_i) begin
          state_d     = WAIT;
          fetch_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (fetch_done_i) begin
          state_d             = IDLE;
          tag_d[fetch_slot_q] = fetch_addr_q;
          vld_d[fetch_slot_q] = 1'b1;
          rr_ptr_d            = sel_req_q;
          repl_ptr_d          = (int'(fetch_slot_q) == NumSlots - 1) ? '0 : fetch_slot_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        fetch_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      vld_q        <= '0;
      repl_ptr_q   <= '0;
      rr_ptr_q     <= ReqW'(NumReq - 1);
      sel_req_q    <= '0;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= '0;
      fetch_slot_q <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      repl_ptr_q   <= repl_ptr_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_req_q    <= sel_req_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_slot_q <= fetch_slot_d;
    end
  end

  // Tag storage is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

  assign fetch_req_o  = fetch_req_q;
  assign fetch_addr_o = fetch_addr_q;
  assign fetch_slot_o = fetch_slot_q;

`ifdef TSPI_SWAP_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && (|hit) && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if ((state_q == IDLE) && (|miss_vec) && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tspi_swap_ctrl.sv
// Directed bench for tspi_swap_ctrl; the bench itself plays the TSPI engine (grant / done pulses).
module tb_tspi_swap_ctrl;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0][20:0]  req_addr_i;
  logic [1:0]        valid_i;
  logic [1:0][1:0]   sram_addr_idx_o;
  logic              block_o;
  logic              fetch_req_o;
  logic              fetch_gnt_i;
  logic [20:0]       fetch_addr_o;
  logic [1:0]        fetch_slot_o;
  logic              fetch_done_i;
`ifdef TSPI_SWAP_STATS_EN
  logic [15:0]       hit_count_o;
  logic [15:0]       miss_count_o;
  logic [15:0]       cnt0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  tspi_swap_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_addr_i      (req_addr_i),
    .valid_i         (valid_i),
    .sram_addr_idx_o (sram_addr_idx_o),
    .block_o         (block_o),
    .fetch_req_o     (fetch_req_o),
    .fetch_gnt_i     (fetch_gnt_i),
    .fetch_addr_o    (fetch_addr_o),
    .fetch_slot_o    (fetch_slot_o),
    .fetch_done_i    (fetch_done_i)
`ifdef TSPI_SWAP_STATS_EN
    ,
    .hit_count_o     (hit_count_o),
    .miss_count_o    (miss_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    valid_i = 2'b00;
    rst_i   = 1'b1;
    cyc();
    rst_i   = 1'b0;
    cyc();
  endtask

  // Called in the cycle the miss is visible; returns in the cycle after fetch_done.
  task automatic serve(input string tag, input logic [20:0] a, input logic [1:0] s);
    cyc();
    check({tag, ".req"},  32'(fetch_req_o),  32'd1);
    check({tag, ".addr"}, 32'(fetch_addr_o), 32'(a));
    check({tag, ".slot"}, 32'(fetch_slot_o), 32'(s));
    fetch_gnt_i = 1'b1;
    cyc();
    fetch_gnt_i = 1'b0;
    check({tag, ".blk_wait"}, 32'(block_o), 32'd1);
    fetch_done_i = 1'b1;
    cyc();
    fetch_done_i = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst_i        = 1'b1;
    valid_i      = 2'b00;
    req_addr_i   = '0;
    fetch_gnt_i  = 1'b0;
    fetch_done_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.idx0", 32'(sram_addr_idx_o[0]), 32'd0);
    check("rst.idx1", 32'(sram_addr_idx_o[1]), 32'd0);
    check("rst.blk",  32'(block_o),            32'd0);
    check("rst.req",  32'(fetch_req_o),        32'd0);
    check("rst.addr", 32'(fetch_addr_o),       32'd0);
    check("rst.slot", 32'(fetch_slot_o),       32'd0);
    rst_i = 1'b0;
    cyc();

    // Single miss from an empty table.
    req_addr_i[0] = 21'h00100;
    valid_i       = 2'b01;
    #1;
    check("t1.blk_miss", 32'(block_o), 32'd1);
    serve("t1", 21'h00100, 2'd0);
    check("t1.idx0", 32'(sram_addr_idx_o[0]), 32'd0);
    check("t1.blk",  32'(block_o),            32'd0);

    // Fill all four slots, then a miss beside a live hit must skip the pinned slot.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_addr_i[0] = 21'(16 + k);
      valid_i       = 2'b01;
      #1;
      serve("fill", 21'(16 + k), 2'(k));
    end
    req_addr_i[0] = 21'h10;
    req_addr_i[1] = 21'h20;
    valid_i       = 2'b11;
    #1;
    check("t2.idx0_hit", 32'(sram_addr_idx_o[0]), 32'd0);
    check("t2.blk_miss", 32'(block_o),            32'd1);
    serve("t2", 21'h20, 2'd1);
    check("t2.idx0", 32'(sram_addr_idx_o[0]), 32'd0);
    check("t2.idx1", 32'(sram_addr_idx_o[1]), 32'd1);
    check("t2.blk",  32'(block_o),            32'd0);

    // Duplicate miss: one fetch serves both requesters.
    req_addr_i[0] = 21'h55;
    req_addr_i[1] = 21'h55;
    #1;
    check("t3.blk_miss", 32'(block_o), 32'd1);
    serve("t3", 21'h55, 2'd2);
    check("t3.idx0", 32'(sram_addr_idx_o[0]), 32'd2);
    check("t3.idx1", 32'(sram_addr_idx_o[1]), 32'd2);
    check("t3.blk",  32'(block_o),            32'd0);
    cyc();
    check("t3.no_refetch", 32'(fetch_req_o), 32'd0);
    check("t3.blk_idle",   32'(block_o),     32'd0);

    // Two different misses: requester 0 first after reset, block held across both fetches.
    do_reset();
    req_addr_i[0] = 21'hA;
    req_addr_i[1] = 21'hB;
    valid_i       = 2'b11;
    #1;
    check("t4.blk_miss", 32'(block_o), 32'd1);
    serve("t4a", 21'hA, 2'd0);
    check("t4.blk_between", 32'(block_o),            32'd1);
    check("t4.idx0_mid",    32'(sram_addr_idx_o[0]), 32'd0);
    serve("t4b", 21'hB, 2'd1);
    check("t4.idx0", 32'(sram_addr_idx_o[0]), 32'd0);
    check("t4.idx1", 32'(sram_addr_idx_o[1]), 32'd1);
    check("t4.blk",  32'(block_o),            32'd0);
    // Requester 0 served last, so the next contended pair goes to requester 1 first.
    req_addr_i[0] = 21'hC;
    valid_i       = 2'b01;
    #1;
    serve("t4c", 21'hC, 2'd2);
    req_addr_i[0] = 21'hD;
    req_addr_i[1] = 21'hE;
    valid_i       = 2'b11;
    #1;
    serve("t4d", 21'hE, 2'd3);
    check("t4.blk_between2", 32'(block_o), 32'd1);
    serve("t4e", 21'hD, 2'd0);
    check("t4.idx0_b", 32'(sram_addr_idx_o[0]), 32'd0);
    check("t4.idx1_b", 32'(sram_addr_idx_o[1]), 32'd3);
    check("t4.blk_b",  32'(block_o),            32'd0);

    // Grant withheld (stray done ignored), then reset while waiting.
    do_reset();
    req_addr_i[0] = 21'h77;
    valid_i       = 2'b01;
    #1;
    cyc();
    check("t5.req",  32'(fetch_req_o),  32'd1);
    check("t5.addr", 32'(fetch_addr_o), 32'h77);
    fetch_done_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      fetch_done_i = 1'b0;
      check("t5.req_hold",  32'(fetch_req_o),  32'd1);
      check("t5.addr_hold", 32'(fetch_addr_o), 32'h77);
      check("t5.slot_hold", 32'(fetch_slot_o), 32'd0);
    end
    fetch_gnt_i = 1'b1;
    cyc();
    fetch_gnt_i = 1'b0;
    check("t5.req_wait", 32'(fetch_req_o), 32'd0);
    check("t5.blk_wait", 32'(block_o),     32'd1);
    #2;
    valid_i = 2'b00;
    rst_i   = 1'b1;
    #1;
    check("t5r.idx0", 32'(sram_addr_idx_o[0]), 32'd0);
    check("t5r.idx1", 32'(sram_addr_idx_o[1]), 32'd0);
    check("t5r.blk",  32'(block_o),            32'd0);
    check("t5r.req",  32'(fetch_req_o),        32'd0);
    check("t5r.addr", 32'(fetch_addr_o),       32'd0);
    check("t5r.slot", 32'(fetch_slot_o),       32'd0);
    cyc();
    rst_i   = 1'b0;
    valid_i = 2'b01;
    #1;
    check("t5.blk_after_rst", 32'(block_o), 32'd1);
    serve("t5b", 21'h77, 2'd0);
    check("t5.blk_final", 32'(block_o), 32'd0);

`ifdef TSPI_SWAP_STATS_EN
    cnt0 = hit_count_o;
    repeat (4) cyc();
    check("st.hits", 32'(hit_count_o - cnt0), 32'd4);
    cnt0 = miss_count_o;
    req_addr_i[0] = 21'h78;
    #1;
    serve("st", 21'h78, 2'd1);
    check("st.misses", 32'(miss_count_o - cnt0), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
